// File: rtl/axi_lite_eth_regbank.sv
// AXI4-Lite register bank: RW control regs, RO status regs and a W1C irq pending/enable pair.
// Latency: a write commits one edge after both AW and W are held; read data is registered at the AR handshake.
// Backpressure: AW/W each buffer one beat; a commit waits while BVALID is pending; ARREADY is low while RVALID is high.
module axi_lite_eth_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_NUM_CTRL_REGS    = 4,
    parameter int C_NUM_STAT_REGS    = 4,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_CTRL_RESET = '0
) (
    input  logic                                          S_AXI_ACLK,
    input  logic                                          S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 S_AXI_AWADDR,
    input  logic [2:0]                                    S_AXI_AWPROT,
    input  logic                                          S_AXI_AWVALID,
    output logic                                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                 S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]               S_AXI_WSTRB,
    input  logic                                          S_AXI_WVALID,
    output logic                                          S_AXI_WREADY,
    output logic [1:0]                                    S_AXI_BRESP,
    output logic                                          S_AXI_BVALID,
    input  logic                                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 S_AXI_ARADDR,
    input  logic [2:0]                                    S_AXI_ARPROT,
    input  logic                                          S_AXI_ARVALID,
    output logic                                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                 S_AXI_RDATA,
    output logic [1:0]                                    S_AXI_RRESP,
    output logic                                          S_AXI_RVALID,
    input  logic                                          S_AXI_RREADY,
    output logic [C_NUM_CTRL_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_out,
    input  logic [C_NUM_STAT_REGS*C_S_AXI_DATA_WIDTH-1:0] stat_in,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                 irq_event,
    output logic                                          irq
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int SW       = DW / 8;
    localparam int NC       = C_NUM_CTRL_REGS;
    localparam int NS       = C_NUM_STAT_REGS;
    localparam int ADDR_LSB = $clog2(SW);
    localparam int IW       = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int T        = NC + NS + 2;

    // Indices are compared one bit wider so T == 2^IW still decodes correctly.
    localparam logic [IW:0] PEND_IX = (IW+1)'(NC + NS);
    localparam logic [IW:0] EN_IX   = (IW+1)'(NC + NS + 1);
    localparam logic [IW:0] T_IX    = (IW+1)'(T);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic          rst_done_q;
    logic          aw_full_q;
    logic [IW-1:0] aw_idx_q;
    logic          w_full_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic          bvalid_q;
    logic [1:0]    bresp_q;
    logic          rvalid_q;
    logic [1:0]    rresp_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] ctrl_q [NC];
    logic [DW-1:0] ctrl_d [NC];
    logic [DW-1:0] pend_q, pend_d;
    logic [DW-1:0] en_q, en_d;
    logic          irq_q;

    logic          aw_hs, w_hs, ar_hs, commit;
    logic [IW:0]   aw_ix, ar_ix;
    logic          aw_err, ar_err;
    logic [DW-1:0] clr_mask;
    logic [DW-1:0] rd_val;
    logic          unused_ok;

    function automatic logic [DW-1:0] strb_mask(input logic [SW-1:0] strb);
        logic [DW-1:0] m;
        for (int b = 0; b < SW; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] m;
        m = strb_mask(strb);
        return (new_v & m) | (old_v & ~m);
    endfunction

    assign S_AXI_AWREADY = rst_done_q & ~aw_full_q;
    assign S_AXI_WREADY  = rst_done_q & ~w_full_q;
    assign S_AXI_ARREADY = rst_done_q & ~rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign irq           = irq_q;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit = aw_full_q & w_full_q & ~bvalid_q;
    assign aw_ix  = {1'b0, aw_idx_q};
    assign ar_ix  = {1'b0, S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]};
    assign aw_err = (aw_ix >= T_IX);
    assign ar_err = (ar_ix >= T_IX);

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    for (genvar g = 0; g < NC; g++) begin : g_ctrl_out
        assign ctrl_out[g*DW +: DW] = ctrl_q[g];
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        en_d     = en_q;
        clr_mask = '0;
        if (commit) begin
            for (int i = 0; i < NC; i++) begin
                if (aw_ix == (IW+1)'(i)) begin
                    ctrl_d[i] = merge(ctrl_q[i], w_data_q, w_strb_q);
                end
            end
            if (aw_ix == EN_IX) begin
                en_d = merge(en_q, w_data_q, w_strb_q);
            end
            if (aw_ix == PEND_IX) begin
                clr_mask = w_data_q & strb_mask(w_strb_q);
            end
        end
        // New events are OR'd after the clear so a coincident event survives.
        pend_d = (pend_q & ~clr_mask) | irq_event;
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NC; i++) begin
            if (ar_ix == (IW+1)'(i)) rd_val = ctrl_q[i];
        end
        for (int j = 0; j < NS; j++) begin
            if (ar_ix == (IW+1)'(NC + j)) rd_val = stat_in[j*DW +: DW];
        end
        if (ar_ix == PEND_IX) rd_val = pend_q;
        if (ar_ix == EN_IX)   rd_val = en_q;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rst_done_q <= 1'b0;
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            for (int i = 0; i < NC; i++) ctrl_q[i] <= C_CTRL_RESET;
            pend_q     <= '0;
            en_q       <= '0;
            irq_q      <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;

            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_idx_q  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
            end else if (commit) begin
                aw_full_q <= 1'b0;
            end

            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end else if (commit) begin
                w_full_q <= 1'b0;
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= aw_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end

            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rresp_q  <= ar_err ? RESP_SLVERR : RESP_OKAY;
                rdata_q  <= ar_err ? '0 : rd_val;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end

            ctrl_q <= ctrl_d;
            pend_q <= pend_d;
            en_q   <= en_d;
            irq_q  <= |(pend_q & en_q);
        end
    end

endmodule

// File: tb/tb_axi_lite_eth_regbank.sv
// Directed bench for axi_lite_eth_regbank with NC=NS=4, 32-bit data, 6-bit address.
module tb_axi_lite_eth_regbank;

    logic         clk;
    logic         aresetn;
    logic [5:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid, wready;
    logic [1:0]   bresp;
    logic         bvalid, bready;
    logic         arvalid, arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid, rready;
    logic [127:0] ctrl_out;
    logic [127:0] stat_in;
    logic [31:0]  irq_event;
    logic         irq;

    int checks = 0;
    int fails  = 0;

    axi_lite_eth_regbank dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (aresetn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .ctrl_out      (ctrl_out),
        .stat_in       (stat_in),
        .irq_event     (irq_event),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] r);
        int   n;
        logic aw_now, w_now;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_now = awready;
            w_now  = wready;
            tick();
            n++;
            if (aw_now) awvalid = 1'b0;
            if (w_now)  wvalid  = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bvalid !== 1'b1) begin
            fails++;
            $display("FAIL wr_timeout addr=%h bvalid=%b required 1", a, bvalid);
        end
        r = bresp;
        tick();
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
        int   n;
        logic hs;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 20) begin
            hs = arready;
            tick();
            n++;
        end
        arvalid = 1'b0;
        checks++;
        if (!hs || rvalid !== 1'b1) begin
            fails++;
            $display("FAIL rd_timeout addr=%h rvalid=%b required 1", a, rvalid);
        end
        d = rdata;
        r = rresp;
        tick();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) tick();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, irq} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags got=%b required 000000",
                     {awready, wready, arready, bvalid, rvalid, irq});
        end
        checks++;
        if ({bresp, rresp, rdata} !== 36'h0 || ctrl_out !== 128'h0) begin
            fails++;
            $display("FAIL reset_values bresp=%h rresp=%h rdata=%h ctrl=%h required all 0",
                     bresp, rresp, rdata, ctrl_out);
        end
        aresetn = 1'b1;
        tick();
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            fails++;
            $display("FAIL reset_release_readys got=%b required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_basic_rw();
        logic [1:0]  r;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(i * 4), 32'(i + 1), 4'hF, r);
            checks++;
            if (r !== 2'b00) begin
                fails++;
                $display("FAIL basic_bresp idx=%0d got=%b required 00", i, r);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(i * 4), d, r);
            checks++;
            if (d !== 32'(i + 1) || r !== 2'b00) begin
                fails++;
                $display("FAIL basic_read idx=%0d got=%h/%b required %h/00", i, d, r, i + 1);
            end
        end
        checks++;
        if (ctrl_out !== 128'h00000004_00000003_00000002_00000001) begin
            fails++;
            $display("FAIL basic_ctrl_out got=%h required 00000004000000030000000200000001", ctrl_out);
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(6'h00, 32'hAABBCCDD, 4'hF, r);
        axi_write(6'h00, 32'h11223344, 4'b0101, r);
        axi_read(6'h00, d, r);
        checks++;
        if (d !== 32'hAA22CC44) begin
            fails++;
            $display("FAIL strobe_merge got=%h required AA22CC44", d);
        end
    endtask

    task automatic test_write_timing();
        bready = 1'b0;
        wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        checks++;
        if (wready !== 1'b0 || bvalid !== 1'b0) begin
            fails++;
            $display("FAIL wt_w_held wready=%b bvalid=%b required 0/0", wready, bvalid);
        end
        tick();
        tick();
        awaddr = 6'h04; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        checks++;
        if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0 || ctrl_out[63:32] !== 32'h2) begin
            fails++;
            $display("FAIL wt_both_full awready=%b wready=%b bvalid=%b ctrl1=%h required 0/0/0/2",
                     awready, wready, bvalid, ctrl_out[63:32]);
        end
        tick();
        checks++;
        if (bvalid !== 1'b1 || ctrl_out[63:32] !== 32'h55) begin
            fails++;
            $display("FAIL wt_commit bvalid=%b ctrl1=%h required 1/55", bvalid, ctrl_out[63:32]);
        end
        awaddr = 6'h08; wdata = 32'h66; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || ctrl_out[95:64] !== 32'h3) begin
                fails++;
                $display("FAIL wt_stall k=%0d bvalid=%b bresp=%b awready=%b ctrl2=%h required 1/00/0/3",
                         k, bvalid, bresp, awready, ctrl_out[95:64]);
            end
        end
        bready = 1'b1;
        tick();
        checks++;
        if (bvalid !== 1'b0) begin
            fails++;
            $display("FAIL wt_bhs bvalid=%b required 0", bvalid);
        end
        tick();
        checks++;
        if (bvalid !== 1'b1 || ctrl_out[95:64] !== 32'h66) begin
            fails++;
            $display("FAIL wt_second_commit bvalid=%b ctrl2=%h required 1/66", bvalid, ctrl_out[95:64]);
        end
        tick();
    endtask

    task automatic test_status();
        logic [1:0]  r;
        logic [31:0] d;
        stat_in[31:0] = 32'hDEADBEEF;
        axi_read(6'h10, d, r);
        checks++;
        if (d !== 32'hDEADBEEF || r !== 2'b00) begin
            fails++;
            $display("FAIL stat_read got=%h/%b required DEADBEEF/00", d, r);
        end
        axi_write(6'h10, 32'h0, 4'hF, r);
        checks++;
        if (r !== 2'b00) begin
            fails++;
            $display("FAIL stat_write_bresp got=%b required 00", r);
        end
        axi_read(6'h10, d, r);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL stat_reread got=%h required DEADBEEF", d);
        end
    endtask

    task automatic test_irq();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(6'h24, 32'h1, 4'hF, r);
        irq_event = 32'h1;
        tick();
        irq_event = 32'h0;
        tick();
        checks++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL irq_rise got=%b required 1", irq);
        end
        awaddr = 6'h20; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        irq_event = 32'h1;
        tick();
        irq_event = 32'h0;
        checks++;
        if (bvalid !== 1'b1) begin
            fails++;
            $display("FAIL irq_w1c_commit bvalid=%b required 1", bvalid);
        end
        tick();
        axi_read(6'h20, d, r);
        checks++;
        if (d !== 32'h1 || irq !== 1'b1) begin
            fails++;
            $display("FAIL irq_set_wins pend=%h irq=%b required 1/1", d, irq);
        end
        axi_write(6'h20, 32'h1, 4'hF, r);
        checks++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL irq_clear got=%b required 0", irq);
        end
        axi_read(6'h20, d, r);
        checks++;
        if (d !== 32'h0) begin
            fails++;
            $display("FAIL irq_pend_cleared got=%h required 0", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(6'h28, 32'hFFFFFFFF, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin
            fails++;
            $display("FAIL oor_bresp got=%b required 10", r);
        end
        axi_read(6'h28, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            fails++;
            $display("FAIL oor_read got=%h/%b required 0/10", d, r);
        end
        axi_read(6'h3C, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            fails++;
            $display("FAIL oor_read_top got=%h/%b required 0/10", d, r);
        end
        checks++;
        if (ctrl_out !== 128'h00000004_00000066_00000055_AA22CC44) begin
            fails++;
            $display("FAIL oor_no_change ctrl=%h required 0000000400000066 00000055AA22CC44", ctrl_out);
        end
        axi_read(6'h24, d, r);
        checks++;
        if (d !== 32'h1 || r !== 2'b00) begin
            fails++;
            $display("FAIL oor_en_intact got=%h/%b required 1/00", d, r);
        end
    endtask

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        stat_in = '0; irq_event = '0;
        test_reset();
        test_basic_rw();
        test_strobe();
        test_write_timing();
        test_status();
        test_irq();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/axi_lite_eth_regbank.md
# axi_lite_eth_regbank

Parametrised AXI4-Lite slave register bank for the Ethernet FPGA custom AXI IP; next generation of the fixed four-register S00_AXI slave. Provides N read/write control registers with byte strobes, M read-only status registers sampled from the Ethernet datapath, and a write-1-to-clear interrupt pending/enable pair driving one level interrupt. Out-of-range accesses return SLVERR. Sits between the PS interconnect (or AXI VIP master in simulation) and the Ethernet core.

## Interface
- C_S_AXI_DATA_WIDTH, 32, bus data width; 32 or 64 only
- C_S_AXI_ADDR_WIDTH, 6, byte address width; 2^(ADDR_WIDTH-ADDR_LSB) >= T required
- C_NUM_CTRL_REGS, 4, NC; RW control registers, index 0..NC-1
- C_NUM_STAT_REGS, 4, NS; RO status registers, index NC..NC+NS-1
- C_CTRL_RESET, 0, reset value of every control register
- Derived: ADDR_LSB = clog2(DW/8); T = NC+NS+2; IRQ_PEND index NC+NS, IRQ_EN index NC+NS+1
- S_AXI_ACLK  in  1  clock; all logic on rising edge
- S_AXI_ARESETN  in  1  synchronous, active-low reset
- S_AXI_AWADDR/AWPROT/AWVALID in, AWREADY out  ADDR_WIDTH/3/1/1  write address; AWPROT ignored
- S_AXI_WDATA/WSTRB/WVALID in, WREADY out  DW/DW/8/1/1  write data
- S_AXI_BRESP/BVALID out, BREADY in  2/1/1  write response
- S_AXI_ARADDR/ARPROT/ARVALID in, ARREADY out  ADDR_WIDTH/3/1/1  read address; ARPROT ignored
- S_AXI_RDATA/RRESP/RVALID out, RREADY in  DW/2/1/1  read data
- ctrl_out  out  NC*DW  control registers, reg i at [i*DW +: DW]
- stat_in  in  NS*DW  status inputs, same packing
- irq_event  in  DW  per-bit one-cycle event pulses
- irq  out  1  |(IRQ_PEND & IRQ_EN), registered

## Operation
- Decode: index = addr[ADDR_WIDTH-1:ADDR_LSB]; low ADDR_LSB bits ignored; index >= T -> OKAY never, SLVERR (2'b10), no state change, RDATA = 0.
- Write channel: AW and W accepted independently into one-entry holding registers (aw_full, w_full). AWREADY = !aw_full; WREADY = !w_full.
- Commit: on edge where aw_full & w_full & !BVALID: perform write, clear aw_full/w_full, set BVALID, BRESP per decode. BVALID held until BREADY; cleared on BVALID&BREADY edge.
- Control write: per byte b, reg[b] <= WSTRB[b] ? WDATA[b] : reg[b].
- Status write: ignored, BRESP OKAY.
- IRQ_PEND write: W1C per strobed byte; bits with WDATA=1 cleared. Each edge, pend |= irq_event. Same-cycle set and clear of a bit: set wins.
- IRQ_EN write: plain RW with strobes, reset 0.
- Read: ARREADY = !RVALID. On AR handshake edge RDATA/RRESP registered from current (pre-edge) values, RVALID set; held stable until RREADY; cleared on RVALID&RREADY edge. Status reads return stat_in sampled at handshake edge.
- Read and write commit to same register on same edge: read returns old value.
- Reads and writes fully independent; no ordering between channels.

## Timing
- Reset (ARESETN=0 at rising edge): AWREADY, WREADY, ARREADY, BVALID, RVALID, irq = 0; BRESP, RRESP, RDATA = 0; ctrl regs = C_CTRL_RESET; IRQ_PEND, IRQ_EN = 0; holding registers empty. Readys high from first edge with ARESETN=1.
- Reset mid-transaction: in-flight AW/W/B/R discarded, no commit, no response.
- Write latency: AW and W handshaked same edge k -> register updated and BVALID high at edge k+1. AW/W on different edges -> commit one edge after the later. BREADY low: next commit stalls; one further AW and W may still be buffered.
- Sustained throughput with BREADY=1: one write per 2 cycles; one read per 2 cycles with RREADY=1.
- ctrl_out reflects committed value the cycle after commit edge; irq rises one edge after pend&en becomes nonzero.

## Test plan
- Reset then write 0x1,0x2,0x3,0x4 to 0x00..0x0C, read back -> RDATA 0x1..0x4, RRESP/BRESP OKAY, ctrl_out matches.
- Write 0xAABBCCDD to ctrl0, then 0x11223344 with WSTRB=4'b0101 -> read 0xAA22CC44.
- W presented 3 cycles before AW, BREADY held low 4 cycles -> single commit one edge after AW handshake, BVALID stable until BREADY, AWREADY low while both slots full.
- stat_in reg0 = 0xDEADBEEF, read index NC -> 0xDEADBEEF; write 0 there -> OKAY, next read still 0xDEADBEEF.
- IRQ_EN=0x1, pulse irq_event[0] -> irq=1; W1C 0x1 same cycle as new irq_event[0] pulse -> pend bit stays 1; W1C alone -> irq=0 next cycle.
- Read/write index T (e.g. 0x28 for NC=NS=4) -> SLVERR, RDATA 0, no register changes.
